// File: rtl/vram_line_arbiter.sv
// ---------------------------------------------------------------------------
// vram_line_arbiter
//   Sole owner of the line-wide VRAM block-RAM port. Display scanout reads
//   are served first; the text-writer path is granted a bounded read-modify-
//   write "turn" only when a turn is started during blanking.
//
//   Optional feature macro: VRAM_WRITE_GUARD_EN
//     defined   : commits to lines >= NUM_LINES are dropped and wr_err is set
//                 (sticky until rst).
//     undefined : no address check, wr_err is constant 0.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   blank           display blanking; a writer turn may start only when high
//   disp_req        1-cycle request for line disp_addr
//   disp_line       line data for scanout, held until the next read
//   disp_valid      1-cycle pulse, disp_line valid
//   disp_overrun    sticky: a request arrived while one was still pending
//   vram_addr       writer target line, sampled when a turn starts
//   vram_in         target line contents handed to the writer
//   vram_turn       writer turn window
//   activate_write  writer commits vram_out (honoured only inside the window)
//   vram_out        modified line from the writer
//   ram_addr/ram_we/ram_wdata/ram_rdata
//                   BRAM port, ram_rdata has one cycle of registered latency
//   wr_err          sticky out-of-range commit flag (guard build only)
// ---------------------------------------------------------------------------
module vram_line_arbiter #(
  parameter int LINE_W      = 640,
  parameter int ADDR_W      = 9,
  parameter int NUM_LINES   = 480,
  parameter int TURN_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              blank,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [LINE_W-1:0] disp_line,
  output logic              disp_valid,
  output logic              disp_overrun,
  input  logic [ADDR_W-1:0] vram_addr,
  output logic [LINE_W-1:0] vram_in,
  output logic              vram_turn,
  input  logic              activate_write,
  input  logic [LINE_W-1:0] vram_out,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [LINE_W-1:0] ram_wdata,
  input  logic [LINE_W-1:0] ram_rdata,
  output logic              wr_err
);

  localparam int CNT_W = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TURN_CYCLES - 1);
`ifdef VRAM_WRITE_GUARD_EN
  localparam logic [ADDR_W:0] LINES_LIM = (ADDR_W + 1)'(NUM_LINES);
`endif

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_DISP_RD   = 3'd1,
    S_DISP_DATA = 3'd2,
    S_WR_RD     = 3'd3,
    S_WR_TURN   = 3'd4,
    S_WR_COMMIT = 3'd5
  } state_t;

  state_t            state_r, state_s;

  logic              pend_valid_r;
  logic [ADDR_W-1:0] pend_addr_r;
  logic              pend_clr_s;
  logic              overrun_r;

  logic [ADDR_W-1:0] wa_r, wa_s;
  logic [CNT_W-1:0]  turn_cnt_r, turn_cnt_s;

  logic [ADDR_W-1:0] ram_addr_r, ram_addr_s;
  logic              ram_we_r, ram_we_s;
  logic [LINE_W-1:0] ram_wdata_r, ram_wdata_s;
  logic [LINE_W-1:0] vram_in_r, vram_in_s;
  logic              vram_turn_r, vram_turn_s;
  logic [LINE_W-1:0] disp_line_r, disp_line_s;
  logic              disp_valid_r, disp_valid_s;
  logic              wr_err_r, wr_err_s;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; a pending display read beats a writer turn in IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (pend_valid_r) begin
          state_s = S_DISP_RD;
        end else if (blank) begin
          state_s = S_WR_RD;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_DISP_RD:   state_s = S_DISP_DATA;
      S_DISP_DATA: state_s = S_IDLE;
      S_WR_RD:     state_s = S_WR_TURN;
      S_WR_TURN: begin
        if (activate_write) begin
          state_s = S_WR_COMMIT;
        end else if (turn_cnt_r == CNT_LAST) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_WR_TURN;
        end
      end
      S_WR_COMMIT: state_s = S_IDLE;
      default:     state_s = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs. The BRAM address is
  // loaded on the way into a read state so the read data arrives one state
  // later; ram_we is loaded on the way into WR_COMMIT so it is high there.
  always_comb begin
    ram_addr_s   = ram_addr_r;
    ram_we_s     = 1'b0;
    ram_wdata_s  = ram_wdata_r;
    wa_s         = wa_r;
    vram_in_s    = vram_in_r;
    vram_turn_s  = 1'b0;
    turn_cnt_s   = turn_cnt_r;
    disp_line_s  = disp_line_r;
    disp_valid_s = 1'b0;
    wr_err_s     = wr_err_r;
    pend_clr_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (pend_valid_r) begin
          ram_addr_s = pend_addr_r;
          pend_clr_s = 1'b1;
        end else if (blank) begin
          wa_s       = vram_addr;
          ram_addr_s = vram_addr;
        end else begin
          ram_addr_s = ram_addr_r;
        end
      end
      S_DISP_RD: begin
        ram_addr_s = ram_addr_r;
      end
      S_DISP_DATA: begin
        disp_line_s  = ram_rdata;
        disp_valid_s = 1'b1;
      end
      S_WR_RD: begin
        vram_turn_s = 1'b1;
        turn_cnt_s  = {CNT_W{1'b0}};
      end
      S_WR_TURN: begin
        // Read data for wa arrives during the first turn cycle.
        if (turn_cnt_r == {CNT_W{1'b0}}) begin
          vram_in_s = ram_rdata;
        end else begin
          vram_in_s = vram_in_r;
        end
        if (activate_write) begin
          ram_addr_s  = wa_r;
          ram_wdata_s = vram_out;
`ifdef VRAM_WRITE_GUARD_EN
          if ({1'b0, wa_r} >= LINES_LIM) begin
            wr_err_s = 1'b1;
          end else begin
            ram_we_s = 1'b1;
          end
`else
          ram_we_s = 1'b1;
`endif
        end else if (turn_cnt_r == CNT_LAST) begin
          vram_turn_s = 1'b0;
        end else begin
          vram_turn_s = 1'b1;
          turn_cnt_s  = turn_cnt_r + CNT_W'(1);
        end
      end
      S_WR_COMMIT: begin
        ram_we_s = 1'b0;
      end
      default: begin
        ram_we_s = 1'b0;
      end
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_addr_r   <= {ADDR_W{1'b0}};
      ram_we_r     <= 1'b0;
      ram_wdata_r  <= {LINE_W{1'b0}};
      wa_r         <= {ADDR_W{1'b0}};
      vram_in_r    <= {LINE_W{1'b0}};
      vram_turn_r  <= 1'b0;
      turn_cnt_r   <= {CNT_W{1'b0}};
      disp_line_r  <= {LINE_W{1'b0}};
      disp_valid_r <= 1'b0;
      wr_err_r     <= 1'b0;
    end else begin
      ram_addr_r   <= ram_addr_s;
      ram_we_r     <= ram_we_s;
      ram_wdata_r  <= ram_wdata_s;
      wa_r         <= wa_s;
      vram_in_r    <= vram_in_s;
      vram_turn_r  <= vram_turn_s;
      turn_cnt_r   <= turn_cnt_s;
      disp_line_r  <= disp_line_s;
      disp_valid_r <= disp_valid_s;
      wr_err_r     <= wr_err_s;
    end
  end

  // One-deep display request slot. A request landing in the same cycle the
  // slot is consumed refills it without counting as an overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid_r <= 1'b0;
      pend_addr_r  <= {ADDR_W{1'b0}};
      overrun_r    <= 1'b0;
    end else if (disp_req) begin
      pend_valid_r <= 1'b1;
      pend_addr_r  <= disp_addr;
      if (pend_valid_r && !pend_clr_s) begin
        overrun_r <= 1'b1;
      end
    end else if (pend_clr_s) begin
      pend_valid_r <= 1'b0;
    end
  end

  assign ram_addr     = ram_addr_r;
  assign ram_we       = ram_we_r;
  assign ram_wdata    = ram_wdata_r;
  assign vram_in      = vram_in_r;
  assign vram_turn    = vram_turn_r;
  assign disp_line    = disp_line_r;
  assign disp_valid   = disp_valid_r;
  assign disp_overrun = overrun_r;
  assign wr_err       = wr_err_r;

endmodule

// File: tb/tb_vram_line_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vram_line_arbiter
//   Self-checking bench for vram_line_arbiter. A behavioural BRAM sits on the
//   RAM port; ref_mem holds the expected RAM contents and is updated only from
//   the bench's own expectation of which commits land.
// ---------------------------------------------------------------------------
module tb_vram_line_arbiter;
  localparam int LINE_W      = 640;
  localparam int ADDR_W      = 9;
  localparam int NUM_LINES   = 480;
  localparam int TURN_CYCLES = 4;
  localparam int DEPTH       = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              blank;
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic [LINE_W-1:0] disp_line;
  logic              disp_valid;
  logic              disp_overrun;
  logic [ADDR_W-1:0] vram_addr;
  logic [LINE_W-1:0] vram_in;
  logic              vram_turn;
  logic              activate_write;
  logic [LINE_W-1:0] vram_out;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [LINE_W-1:0] ram_wdata;
  logic [LINE_W-1:0] ram_rdata;
  logic              wr_err;

  logic              load_mem;
  logic [LINE_W-1:0] bram    [0:DEPTH-1];
  logic [LINE_W-1:0] ref_mem [0:DEPTH-1];
  logic              exp_wr_err;

  int n_cmp = 0;
  int n_bad = 0;
  int we_cnt = 0;
  logic [ADDR_W-1:0] last_we_addr = '0;
  logic [LINE_W-1:0] last_we_data = '0;

  vram_line_arbiter #(
    .LINE_W(LINE_W), .ADDR_W(ADDR_W), .NUM_LINES(NUM_LINES), .TURN_CYCLES(TURN_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .blank(blank),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_line(disp_line),
    .disp_valid(disp_valid), .disp_overrun(disp_overrun),
    .vram_addr(vram_addr), .vram_in(vram_in), .vram_turn(vram_turn),
    .activate_write(activate_write), .vram_out(vram_out),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  // Behavioural BRAM: one-cycle registered read, bulk load from ref_mem.
  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < DEPTH; i++) bram[i] <= ref_mem[i];
    end else if (ram_we) begin
      bram[ram_addr] <= ram_wdata;
    end
    ram_rdata <= bram[ram_addr];
  end

  // Write-port monitor.
  always @(negedge clk) begin
    if (ram_we) begin
      we_cnt       <= we_cnt + 1;
      last_we_addr <= ram_addr;
      last_we_data <= ram_wdata;
    end
  end

  task automatic check_eq(input string tag, input logic [LINE_W-1:0] got,
                          input logic [LINE_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    for (int i = 0; i < LINE_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Single display read with blank low: data due 3 cycles after the request.
  task automatic read_test(input logic [ADDR_W-1:0] a, input string tag);
    int lat;
    lat = -1;
    @(posedge clk); #1;
    disp_req = 1'b1; disp_addr = a;
    @(posedge clk); #1;
    disp_req = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (vram_turn) check_eq({tag, "_no_turn"}, vram_turn, 1'b0);
      if (disp_valid) begin
        lat = c;
        break;
      end
    end
    check_eq({tag, "_lat"}, lat, 3);
    check_eq({tag, "_line"}, disp_line, ref_mem[a]);
    @(negedge clk);
    check_eq({tag, "_pulse"}, disp_valid, 1'b0);
  endtask

  // One writer turn; commit_at = turn cycle of the commit, 0 or > TURN_CYCLES
  // means none. Stray activate_write is driven before and after the window.
  task automatic turn_test(input logic [ADDR_W-1:0] a, input int commit_at,
                           input logic [LINE_W-1:0] d, input string tag);
    logic [LINE_W-1:0] old_line;
    int we0, seen, after, exp_turn;
    logic exp_commit, exp_we;
    old_line = ref_mem[a];
    we0 = we_cnt; seen = 0; after = 0;
    @(posedge clk); #1;
    vram_addr = a; blank = 1'b1; activate_write = 1'b1; vram_out = ~d;
    @(posedge clk); #1;
    blank = 1'b0; vram_addr = ~a;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (vram_turn) begin
        seen++;
        activate_write = (seen == commit_at);
        vram_out = (seen == commit_at) ? d : ~d;
      end else if (seen > 0) begin
        after++;
        activate_write = (after == 1);
        vram_out = ~d;
        if (after == 6) break;
      end else begin
        activate_write = 1'b1;
        vram_out = ~d;
      end
    end
    activate_write = 1'b0;
    exp_commit = (commit_at >= 1) && (commit_at <= TURN_CYCLES);
    exp_turn = exp_commit ? commit_at : TURN_CYCLES;
    exp_we = exp_commit;
`ifdef VRAM_WRITE_GUARD_EN
    if (exp_commit && (int'(a) >= NUM_LINES)) begin
      exp_we = 1'b0;
      exp_wr_err = 1'b1;
    end
`endif
    check_eq({tag, "_turn_len"}, seen, exp_turn);
    check_eq({tag, "_we_count"}, we_cnt - we0, exp_we ? 1 : 0);
    check_eq({tag, "_vram_in"}, vram_in, old_line);
    check_eq({tag, "_wr_err"}, wr_err, exp_wr_err);
    if (exp_we) begin
      check_eq({tag, "_we_addr"}, last_we_addr, a);
      check_eq({tag, "_we_data"}, last_we_data, d);
      ref_mem[a] = d;
    end
  endtask

  // Display requests colliding with a turn; two_reqs=0: one request (addr 7)
  // on the cycle the turn starts, else requests 7 then 9 inside the window.
  task automatic collide_test(input logic [ADDR_W-1:0] a, input int two_reqs,
                              input string tag);
    int seen, vcnt, vat, vlat;
    logic [LINE_W-1:0] vline;
    logic [ADDR_W-1:0] exp_a;
    seen = 0; vcnt = 0; vat = -1; vlat = -1; vline = '0;
    exp_a = (two_reqs != 0) ? 9'd9 : 9'd7;
    @(posedge clk); #1;
    vram_addr = a; blank = 1'b1;
    if (two_reqs == 0) begin
      disp_req = 1'b1; disp_addr = 9'd7;
    end
    @(posedge clk); #1;
    blank = 1'b0; disp_req = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (vram_turn) begin
        seen++;
        disp_req = (two_reqs != 0) && (seen == 1 || seen == 2);
        disp_addr = (seen == 1) ? 9'd7 : 9'd9;
      end else begin
        disp_req = 1'b0;
      end
      if (disp_valid) begin
        vcnt++;
        if (vcnt == 1) begin
          vline = disp_line; vlat = c; vat = seen;
        end
      end
    end
    check_eq({tag, "_turn_len"}, seen, TURN_CYCLES);
    check_eq({tag, "_valid_cnt"}, vcnt, 1);
    check_eq({tag, "_after_turn"}, vat, TURN_CYCLES);
    check_eq({tag, "_line"}, vline, ref_mem[exp_a]);
    check_eq({tag, "_overrun"}, disp_overrun, (two_reqs != 0) ? 1'b1 : 1'b0);
    if (two_reqs == 0)
      check_eq({tag, "_lat_bound"}, (vlat >= 0) && (vlat <= TURN_CYCLES + 6), 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_flags"}, {disp_valid, disp_overrun, vram_turn, ram_we, wr_err}, 5'd0);
    check_eq({tag, "_ram_addr"}, ram_addr, 9'd0);
    check_eq({tag, "_disp_line"}, disp_line, '0);
    check_eq({tag, "_vram_in"}, vram_in, '0);
    check_eq({tag, "_ram_wdata"}, ram_wdata, '0);
  endtask

  // Reset asserted inside a turn in the cycle activate_write is raised.
  task automatic reset_test();
    int seen, we0;
    logic [LINE_W-1:0] d;
    seen = 0; we0 = we_cnt; d = rand_line();
    @(posedge clk); #1;
    vram_addr = 9'd100; blank = 1'b1;
    @(posedge clk); #1;
    blank = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (vram_turn) seen++;
      if (seen == 2) begin
        activate_write = 1'b1; vram_out = d;
        #2; rst = 1'b1;
        break;
      end
    end
    check_eq("rst_mid_turn_reached", seen, 2);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("rst_mid");
    @(posedge clk); #1;
    activate_write = 1'b0; rst = 1'b0;
    exp_wr_err = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("rst_no_we", we_cnt - we0, 0);
    check_eq("rst_wr_err", wr_err, 1'b0);
    read_test(9'd100, "rst_read");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; blank = 1'b0; disp_req = 1'b0; disp_addr = '0; vram_addr = '0;
    activate_write = 1'b0; vram_out = '0; load_mem = 1'b0; exp_wr_err = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = rand_line();
    ref_mem[5] = {80{8'hA5}};
    load_mem = 1'b1;
    repeat (2) @(posedge clk);
    #1 load_mem = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    read_test(9'd5, "read5");
    turn_test(9'd340, 2, {80{8'h0F}}, "turn340");
    read_test(9'd340, "read340");
    turn_test(9'd200, 0, rand_line(), "expiry");
    read_test(9'd200, "read200");
    collide_test(9'd50, 0, "coll_start");
    collide_test(9'd60, 1, "coll_two");
    reset_test();
    turn_test(9'd500, 2, rand_line(), "guard500");
    read_test(9'd500, "read500");
    turn_test(9'd12, TURN_CYCLES, rand_line(), "last_cycle");
    turn_test(9'd13, 1, rand_line(), "first_cycle");

    for (int it = 0; it < 40; it++) begin
      logic [ADDR_W-1:0] a;
      if ($urandom_range(0, 1) == 0) begin
        a = ADDR_W'($urandom_range(0, NUM_LINES - 1));
        read_test(a, "rnd_read");
      end else begin
        a = ADDR_W'($urandom_range(0, DEPTH - 1));
        turn_test(a, int'($urandom_range(0, TURN_CYCLES + 1)), rand_line(), "rnd_turn");
        if ($urandom_range(0, 1) == 1) read_test(a, "rnd_readback");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
